// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard/flush/memory-wait control with saturating stall statistics
// and a sticky watchdog for hazard stalls that never resolve.
module pipeline_stall_controller #(
  parameter int COUNT_W        = 16,
  parameter int HAZARD_TIMEOUT = 8,
  parameter int FLUSH_CYCLES   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_detected,
  input  logic               branch_taken,
  input  logic               mem_access,
  input  logic               mem_ready,
  output logic               freeze_pc,
  output logic               freeze_if_id,
  output logic               bubble_id_ex,
  output logic               flush_if_id,
  output logic               freeze_back,
  output logic [COUNT_W-1:0] hazard_stalls,
  output logic [COUNT_W-1:0] mem_stalls,
  output logic [COUNT_W-1:0] flushes,
  output logic               deadlock_error
);

  localparam int RUN_W = $clog2(HAZARD_TIMEOUT + 1);
  localparam int REM_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [REM_W-1:0] FLUSH_LOAD = REM_W'(FLUSH_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT  = RUN_W'(HAZARD_TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  state_t           state;
  logic [REM_W-1:0] flush_rem;
  logic [RUN_W-1:0] hazard_run;

  logic mem_wait;
  logic flush_active;
  logic do_flush;
  logic do_stall;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // MEM_WAIT resumes whichever of RUN/FLUSH it interrupted, decided by the
  // paused flush count.
  assign mem_wait     = mem_access & ~mem_ready;
  assign flush_active = (state == FLUSH) || ((state == MEM_WAIT) && (flush_rem != '0));
  assign do_flush     = ~mem_wait & (branch_taken | flush_active);
  assign do_stall     = ~mem_wait & ~branch_taken & ~flush_active & hazard_detected;

  assign freeze_pc    = ~rst & (mem_wait | do_stall);
  assign freeze_if_id = ~rst & (mem_wait | do_stall);
  assign freeze_back  = ~rst & mem_wait;
  assign bubble_id_ex = ~rst & (do_flush | do_stall);
  assign flush_if_id  = ~rst & do_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      flush_rem      <= '0;
      hazard_run     <= '0;
      hazard_stalls  <= '0;
      mem_stalls     <= '0;
      flushes        <= '0;
      deadlock_error <= 1'b0;
    end else if (mem_wait) begin
      state      <= MEM_WAIT;
      mem_stalls <= sat_inc(mem_stalls);
      hazard_run <= '0;
    end else if (branch_taken) begin
      flushes    <= sat_inc(flushes);
      flush_rem  <= FLUSH_LOAD;
      state      <= (FLUSH_LOAD != '0) ? FLUSH : RUN;
      hazard_run <= '0;
    end else if (flush_active) begin
      flush_rem  <= flush_rem - REM_W'(1);
      state      <= (flush_rem == REM_W'(1)) ? RUN : FLUSH;
      hazard_run <= '0;
    end else begin
      state <= RUN;
      if (hazard_detected) begin
        hazard_stalls <= sat_inc(hazard_stalls);
        if (hazard_run != RUN_LIMIT)
          hazard_run <= hazard_run + RUN_W'(1);
        if (hazard_run >= RUN_LIMIT - RUN_W'(1))
          deadlock_error <= 1'b1;
      end else begin
        hazard_run <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: directed scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_pipeline_stall_controller;

  localparam int COUNT_W = 4;
  localparam int HT      = 8;
  localparam int FC      = 3;
  localparam int SAT     = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst, hazard_detected, branch_taken, mem_access, mem_ready;
  logic freeze_pc, freeze_if_id, bubble_id_ex, flush_if_id, freeze_back;
  logic [COUNT_W-1:0] hazard_stalls, mem_stalls, flushes;
  logic deadlock_error;

  pipeline_stall_controller #(
    .COUNT_W(COUNT_W), .HAZARD_TIMEOUT(HT), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard_detected), .branch_taken(branch_taken),
    .mem_access(mem_access), .mem_ready(mem_ready),
    .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id),
    .bubble_id_ex(bubble_id_ex), .flush_if_id(flush_if_id),
    .freeze_back(freeze_back),
    .hazard_stalls(hazard_stalls), .mem_stalls(mem_stalls),
    .flushes(flushes), .deadlock_error(deadlock_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state: owed flush cycles, hazard run length, statistics
  int m_left, m_run, m_hz, m_mem, m_fl;
  bit m_dead;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic int sat_add(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic step(input bit r, input bit h, input bit b, input bit ma, input bit mr);
    bit mw;
    bit e_fpc, e_fb, e_bub, e_fl;
    rst = r; hazard_detected = h; branch_taken = b; mem_access = ma; mem_ready = mr;
    mw = ma && !mr;
    e_fpc = 0; e_fb = 0; e_bub = 0; e_fl = 0;
    if (!r) begin
      if (mw) begin
        e_fpc = 1; e_fb = 1;
      end else if (b || m_left > 0) begin
        e_fl = 1; e_bub = 1;
      end else if (h) begin
        e_fpc = 1; e_bub = 1;
      end
    end
    #4;
    check_eq("freeze_pc", int'(freeze_pc), int'(e_fpc));
    check_eq("freeze_if_id", int'(freeze_if_id), int'(e_fpc));
    check_eq("freeze_back", int'(freeze_back), int'(e_fb));
    check_eq("bubble_id_ex", int'(bubble_id_ex), int'(e_bub));
    check_eq("flush_if_id", int'(flush_if_id), int'(e_fl));
    check_eq("hazard_stalls", int'(hazard_stalls), m_hz);
    check_eq("mem_stalls", int'(mem_stalls), m_mem);
    check_eq("flushes", int'(flushes), m_fl);
    check_eq("deadlock_error", int'(deadlock_error), int'(m_dead));
    @(posedge clk);
    if (r) begin
      m_left = 0; m_run = 0; m_hz = 0; m_mem = 0; m_fl = 0; m_dead = 0;
    end else if (mw) begin
      m_mem = sat_add(m_mem); m_run = 0;
    end else if (b) begin
      m_fl = sat_add(m_fl); m_left = FC - 1; m_run = 0;
    end else if (m_left > 0) begin
      m_left--; m_run = 0;
    end else if (h) begin
      m_hz = sat_add(m_hz); m_run++;
      if (m_run >= HT) m_dead = 1;
    end else begin
      m_run = 0;
    end
    cyc++;
    #1;
  endtask

  initial begin
    m_left = 0; m_run = 0; m_hz = 0; m_mem = 0; m_fl = 0; m_dead = 0;
    rst = 1; hazard_detected = 0; branch_taken = 0; mem_access = 0; mem_ready = 0;
    // reset with events present: controls must stay low
    step(1, 1, 1, 1, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // two-cycle hazard stall
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("hz_after_2", int'(hazard_stalls), 2);
    // branch with concurrent hazard, then owed flush cycles
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("fl_after_branch", int'(flushes), 1);
    // memory wait 3 cycles then ready; ready without access is no wait
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    check_eq("mem_after_3", int'(mem_stalls), 3);
    // branch, memory wait of 2 on the second flush cycle
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0);
    // held hazard: watchdog and saturation
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    check_eq("hz_saturated", int'(hazard_stalls), SAT);
    check_eq("deadlock_set", int'(deadlock_error), 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    // reset asserted mid-stall
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("deadlock_cleared", int'(deadlock_error), 0);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(255) == 0),
           ($urandom_range(99) < 45),
           ($urandom_range(99) < 10),
           ($urandom_range(99) < 30),
           ($urandom_range(99) < 50));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the per-cycle hazard flag from the ID-stage hazard detector, the EXE-stage branch-taken flag and the MEM-stage memory handshake.
- Drives the freeze, bubble and flush controls for PC, IF/ID, ID/EX, EXE/MEM and MEM/WB.
- Keeps saturating stall statistics and a sticky deadlock watchdog.
- Sits beside the hazard detector in the core top level.

Parameters:
- COUNT_W, 16, width of each saturating statistics counter
- HAZARD_TIMEOUT, 8, consecutive hazard-stall cycles allowed before deadlock_error (must be ≥2)
- FLUSH_CYCLES, 1, cycles IF/ID and ID/EX are flushed per taken branch (≥1)

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- hazard_detected  input  1  ID-stage data hazard, combinational from the hazard detector
- branch_taken  input  1  EXE stage resolved a taken branch/jump this cycle
- mem_access  input  1  MEM stage holds a load/store this cycle
- mem_ready  input  1  data memory completes the access this cycle
- freeze_pc  output  1  hold PC
- freeze_if_id  output  1  hold IF/ID register
- bubble_id_ex  output  1  load NOP into ID/EX
- flush_if_id  output  1  load NOP into IF/ID
- freeze_back  output  1  hold ID/EX, EXE/MEM and MEM/WB (memory wait)
- hazard_stalls  output  COUNT_W  cycles spent in hazard stall
- mem_stalls  output  COUNT_W  cycles spent in memory wait
- flushes  output  COUNT_W  taken branches serviced
- deadlock_error  output  1  sticky watchdog flag

Behaviour:
- States: RUN, MEM_WAIT, FLUSH. State, counters and deadlock_error are registered. Control outputs are combinational from state plus the current inputs, so they act in the same cycle.
- Reset (rst high at posedge): state=RUN, all counters=0, deadlock_error=0, internal hazard-run counter=0, flush-remaining counter=0. While rst is high, all control outputs=0.
- Priority each cycle: memory wait > branch flush > hazard stall.
- Memory wait (any state): mem_access && !mem_ready.
  - freeze_pc=freeze_if_id=freeze_back=1; bubble_id_ex=flush_if_id=0.
  - Next state MEM_WAIT; mem_stalls increments.
  - branch_taken and hazard_detected are ignored: the stages are frozen and the signals are re-presented.
  - FLUSH progress is paused, not lost.
- MEM_WAIT: remains while mem_access && !mem_ready. On mem_ready, returns to FLUSH if flushes remain, else RUN. That cycle is evaluated as a RUN/FLUSH cycle.
- Branch (no memory wait, branch_taken=1):
  - flush_if_id=1, bubble_id_ex=1, freeze_pc=freeze_if_id=0 (PC takes the target).
  - flushes increments. Flush-remaining loads FLUSH_CYCLES-1; next state is FLUSH if that value is >0, else RUN.
  - A concurrent hazard_detected is discarded: hazard_stalls does not increment and the run counter clears.
- FLUSH: flush_if_id=bubble_id_ex=1 each cycle; the remaining count decrements and the state returns to RUN at 0. A new branch_taken in FLUSH reloads the count and increments flushes.
- Hazard (RUN, no memory wait, no branch, hazard_detected=1):
  - freeze_pc=freeze_if_id=1, bubble_id_ex=1, flush_if_id=0, freeze_back=0.
  - hazard_stalls increments; run counter increments.
  - Otherwise the run counter clears to 0, including during memory wait.
- Watchdog: when the run counter reaches HAZARD_TIMEOUT, deadlock_error sets on that clock edge and stays set until rst. Control behaviour is unchanged.
- Counters saturate at 2^COUNT_W-1 and never wrap.
- Idle (no events): all controls 0.

Test Plan:
- Reset, then hazard_detected=1 for 2 cycles → freeze_pc/freeze_if_id/bubble_id_ex high exactly 2 cycles, hazard_stalls=2, deadlock_error=0.
- branch_taken=1 with hazard_detected=1, FLUSH_CYCLES=1 → flush_if_id=bubble_id_ex=1 for 1 cycle, freeze_pc=0, flushes=1, hazard_stalls=0.
- mem_access=1, mem_ready=0 for 3 cycles then 1 → freeze_back high 3 cycles, mem_stalls=3, state back to RUN on the 4th cycle with no freeze.
- FLUSH_CYCLES=3, branch taken, memory wait of 2 cycles on the 2nd flush cycle → 3 total flush cycles, with 2 frozen cycles in between and no flush asserted during the wait.
- hazard_detected held high, HAZARD_TIMEOUT=8 → deadlock_error rises after the 8th stall edge and stays high after hazard drops; clears only on rst.
- COUNT_W=4, 20 hazard cycles → hazard_stalls saturates at 15. rst asserted mid-stall → all outputs 0 on the next edge.
